// File: rtl/alu_op_sequencer_if.sv
// Control bundle between the ALU op sequencer and DataPath.
// master = sequencer side, slave = DataPath / top-level side.
interface alu_op_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic [15:0] regIn;
    logic [15:0] regOut;
    logic        HiIn;
    logic        LoIn;
    logic        ZIn;
    logic        PCIn;
    logic        MDRIn;
    logic        YIn;
    logic        MARIn;
    logic        IRIn;
    logic        IncPC;
    logic        HiOut;
    logic        LoOut;
    logic        ZHiOut;
    logic        ZLoOut;
    logic        PCOut;
    logic        MDROut;
    logic        MDRread;
    logic [4:0]  ALUcode;
    logic        busy;
    logic        done;
    logic        illegal;

    modport master (
        input  start, ir,
        output regIn, regOut,
        output HiIn, LoIn, ZIn, PCIn, MDRIn,
        output YIn, MARIn, IRIn, IncPC,
        output HiOut, LoOut, ZHiOut, ZLoOut,
        output PCOut, MDROut, MDRread,
        output ALUcode, busy, done, illegal
    );

    modport slave (
        output start, ir,
        input  regIn, regOut,
        input  HiIn, LoIn, ZIn, PCIn, MDRIn,
        input  YIn, MARIn, IRIn, IncPC,
        input  HiOut, LoOut, ZHiOut, ZLoOut,
        input  PCOut, MDROut, MDRread,
        input  ALUcode, busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Hardwired T-state sequencer: fetch plus register-register ALU class.
// Outputs decode only registered state and the fields latched at T3.
module alu_op_sequencer #(
    parameter int         MEM_WAIT = 1,
    parameter logic [4:0] OP_MUL   = 5'b01111,
    parameter logic [4:0] OP_DIV   = 5'b10000,
    parameter logic [4:0] OP_NEG   = 5'b10001,
    parameter logic [4:0] OP_NOT   = 5'b10010
) (
    input logic                 clock,
    input logic                 clear,
    alu_op_sequencer_if.master  bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_T0    = 4'd1;
    localparam logic [3:0] S_T1    = 4'd2;
    localparam logic [3:0] S_T2    = 4'd3;
    localparam logic [3:0] S_T3    = 4'd4;
    localparam logic [3:0] S_T4    = 4'd5;
    localparam logic [3:0] S_T5    = 4'd6;
    localparam logic [3:0] S_T6    = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;
    localparam logic [3:0] S_FAULT = 4'd9;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    logic [3:0] state;
    logic [3:0] state_n;
    logic [3:0] cnt;
    logic [4:0] op_q;
    logic [3:0] ra_q;
    logic [3:0] rb_q;
    logic [3:0] rc_q;

    logic is_bin;
    logic is_md;
    logic is_un;
    logic is_ok;
    logic first_t1;

    logic unused_ir;
    assign unused_ir = ^bus.ir[14:0];

    assign is_bin   = (op_q <= 5'b01000);
    assign is_md    = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign is_un    = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign is_ok    = is_bin || is_md || is_un;
    assign first_t1 = (cnt == WAIT_LOAD);

    function automatic logic [15:0] oh(input logic [3:0] idx);
        return 16'(1) << idx;
    endfunction

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_n = S_T0;
            S_T0:    state_n = S_T1;
            S_T1:    if (cnt == 4'd0) state_n = S_T2;
            S_T2:    state_n = S_T3;
            S_T3: begin
                if (!is_ok)     state_n = S_FAULT;
                else if (is_un) state_n = S_T5;
                else            state_n = S_T4;
            end
            S_T4:    state_n = S_T5;
            S_T5:    state_n = is_md ? S_T6 : S_DONE;
            S_T6:    state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            S_FAULT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            op_q  <= 5'd0;
            ra_q  <= 4'd0;
            rb_q  <= 4'd0;
            rc_q  <= 4'd0;
        end else begin
            state <= state_n;
            if (state == S_T0)
                cnt <= WAIT_LOAD;
            else if (state == S_T1 && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            // fields are captured on T3 entry so IR may change afterwards
            if (state == S_T2) begin
                op_q <= bus.ir[31:27];
                ra_q <= bus.ir[26:23];
                rb_q <= bus.ir[22:19];
                rc_q <= bus.ir[18:15];
            end
        end
    end

    always_comb begin
        bus.regIn   = 16'h0000;
        bus.regOut  = 16'h0000;
        bus.HiIn    = 1'b0;
        bus.LoIn    = 1'b0;
        bus.ZIn     = 1'b0;
        bus.PCIn    = 1'b0;
        bus.MDRIn   = 1'b0;
        bus.YIn     = 1'b0;
        bus.MARIn   = 1'b0;
        bus.IRIn    = 1'b0;
        bus.IncPC   = 1'b0;
        bus.HiOut   = 1'b0;
        bus.LoOut   = 1'b0;
        bus.ZHiOut  = 1'b0;
        bus.ZLoOut  = 1'b0;
        bus.PCOut   = 1'b0;
        bus.MDROut  = 1'b0;
        bus.MDRread = 1'b0;
        bus.ALUcode = 5'b00000;
        bus.busy    = (state != S_IDLE);
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        unique case (state)
            S_T0: begin
                bus.PCOut = 1'b1;
                bus.MARIn = 1'b1;
                bus.IncPC = 1'b1;
                bus.ZIn   = 1'b1;
            end
            S_T1: begin
                bus.ZLoOut  = 1'b1;
                bus.PCIn    = first_t1;
                bus.MDRread = 1'b1;
                bus.MDRIn   = 1'b1;
            end
            S_T2: begin
                bus.MDROut = 1'b1;
                bus.IRIn   = 1'b1;
            end
            S_T3: begin
                if (is_un) begin
                    bus.regOut  = oh(rb_q);
                    bus.ALUcode = op_q;
                    bus.ZIn     = 1'b1;
                end else if (is_ok) begin
                    bus.regOut = oh(rb_q);
                    bus.YIn    = 1'b1;
                end
            end
            S_T4: begin
                bus.regOut  = oh(rc_q);
                bus.ALUcode = op_q;
                bus.ZIn     = 1'b1;
            end
            S_T5: begin
                bus.ZLoOut  = 1'b1;
                bus.ALUcode = op_q;
                if (is_md) bus.LoIn  = 1'b1;
                else       bus.regIn = oh(ra_q);
            end
            S_T6: begin
                bus.ZHiOut = 1'b1;
                bus.HiIn   = 1'b1;
            end
            S_DONE: bus.done = 1'b1;
            S_FAULT: begin
                bus.done    = 1'b1;
                bus.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a per-cycle expected-output queue.
// Two instances cover MEM_WAIT=1 and MEM_WAIT=3.
module tb_alu_op_sequencer;

    logic clock;
    logic clear;

    alu_op_sequencer_if bus1 ();
    alu_op_sequencer_if bus3 ();

    alu_op_sequencer #(.MEM_WAIT(1)) dut1 (
        .clock (clock),
        .clear (clear),
        .bus   (bus1)
    );

    alu_op_sequencer #(.MEM_WAIT(3)) dut3 (
        .clock (clock),
        .clear (clear),
        .bus   (bus3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [14:0] S_HIIN   = 15'h4000;
    localparam logic [14:0] S_LOIN   = 15'h2000;
    localparam logic [14:0] S_ZIN    = 15'h1000;
    localparam logic [14:0] S_PCIN   = 15'h0800;
    localparam logic [14:0] S_MDRIN  = 15'h0400;
    localparam logic [14:0] S_YIN    = 15'h0200;
    localparam logic [14:0] S_MARIN  = 15'h0100;
    localparam logic [14:0] S_IRIN   = 15'h0080;
    localparam logic [14:0] S_INCPC  = 15'h0040;
    localparam logic [14:0] S_HIOUT  = 15'h0020;
    localparam logic [14:0] S_LOOUT  = 15'h0010;
    localparam logic [14:0] S_ZHIOUT = 15'h0008;
    localparam logic [14:0] S_ZLOOUT = 15'h0004;
    localparam logic [14:0] S_PCOUT  = 15'h0002;
    localparam logic [14:0] S_MDROUT = 15'h0001;

    localparam logic [55:0] ZERO = 56'h0;

    int n_cmp;
    int n_bad;
    logic [55:0] exp_q[$];

    function automatic logic [55:0] snap1();
        return {bus1.regIn, bus1.regOut,
                bus1.HiIn, bus1.LoIn, bus1.ZIn, bus1.PCIn, bus1.MDRIn,
                bus1.YIn, bus1.MARIn, bus1.IRIn, bus1.IncPC,
                bus1.HiOut, bus1.LoOut, bus1.ZHiOut, bus1.ZLoOut,
                bus1.PCOut, bus1.MDROut, bus1.MDRread,
                bus1.ALUcode, bus1.busy, bus1.done, bus1.illegal};
    endfunction

    function automatic logic [55:0] snap3();
        return {bus3.regIn, bus3.regOut,
                bus3.HiIn, bus3.LoIn, bus3.ZIn, bus3.PCIn, bus3.MDRIn,
                bus3.YIn, bus3.MARIn, bus3.IRIn, bus3.IncPC,
                bus3.HiOut, bus3.LoOut, bus3.ZHiOut, bus3.ZLoOut,
                bus3.PCOut, bus3.MDROut, bus3.MDRread,
                bus3.ALUcode, bus3.busy, bus3.done, bus3.illegal};
    endfunction

    function automatic logic [55:0] mk(
        input logic [15:0] ri, input logic [15:0] ro,
        input logic [14:0] s, input logic rd, input logic [4:0] alu,
        input logic b, input logic d, input logic il);
        return {ri, ro, s, rd, alu, b, d, il};
    endfunction

    function automatic logic [31:0] mk_ir(
        input logic [4:0] op, input logic [3:0] ra,
        input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    task automatic check(input string tag, input logic [55:0] obs,
                         input logic [55:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] irv, input int mw);
        logic [4:0]  op;
        logic [15:0] ra1, rb1, rc1;
        bit bin, md, un;
        op  = irv[31:27];
        ra1 = 16'h1 << irv[26:23];
        rb1 = 16'h1 << irv[22:19];
        rc1 = 16'h1 << irv[18:15];
        bin = (op <= 5'd8);
        md  = (op == 5'b01111) || (op == 5'b10000);
        un  = (op == 5'b10001) || (op == 5'b10010);
        exp_q.push_back(mk(0, 0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN,
                           0, 0, 1, 0, 0));
        for (int k = 0; k < mw; k++)
            exp_q.push_back(mk(0, 0,
                S_ZLOOUT | S_MDRIN | ((k == 0) ? S_PCIN : 15'h0),
                1, 0, 1, 0, 0));
        exp_q.push_back(mk(0, 0, S_MDROUT | S_IRIN, 0, 0, 1, 0, 0));
        if (un) begin
            exp_q.push_back(mk(0, rb1, S_ZIN, 0, op, 1, 0, 0));
            exp_q.push_back(mk(ra1, 0, S_ZLOOUT, 0, op, 1, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        end else if (bin || md) begin
            exp_q.push_back(mk(0, rb1, S_YIN, 0, 0, 1, 0, 0));
            exp_q.push_back(mk(0, rc1, S_ZIN, 0, op, 1, 0, 0));
            if (md) begin
                exp_q.push_back(mk(0, 0, S_ZLOOUT | S_LOIN, 0, op, 1, 0, 0));
                exp_q.push_back(mk(0, 0, S_ZHIOUT | S_HIIN, 0, 0, 1, 0, 0));
            end else begin
                exp_q.push_back(mk(ra1, 0, S_ZLOOUT, 0, op, 1, 0, 0));
            end
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
        end else begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1));
        end
        exp_q.push_back(ZERO);
        exp_q.push_back(ZERO);
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] irv);
        if (w == 3) begin
            bus3.start = s;
            bus3.ir    = irv;
        end else begin
            bus1.start = s;
            bus1.ir    = irv;
        end
    endtask

    task automatic run(input int w, input logic [31:0] irv,
                       input int restart_at, input string tag);
        int idx;
        logic [55:0] e;
        @(negedge clock);
        drive(w, 1'b1, irv);
        push_exp(irv, (w == 3) ? 3 : 1);
        idx = 0;
        while (exp_q.size() > 0 && idx < 64) begin
            @(negedge clock);
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, idx),
                  (w == 3) ? snap3() : snap1(), e);
            drive(w, idx == restart_at, irv);
            idx++;
        end
        drive(w, 1'b0, irv);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] irv;
        logic [55:0] e;
        n_cmp = 0;
        n_bad = 0;
        clear = 1'b1;
        drive(1, 1'b0, 32'h0);
        drive(3, 1'b0, 32'h0);
        repeat (2) @(negedge clock);
        check("reset1", snap1(), ZERO);
        check("reset3", snap3(), ZERO);
        // start together with clear must not begin an instruction
        drive(1, 1'b1, 32'h0);
        @(negedge clock);
        check("clr_start", snap1(), ZERO);
        drive(1, 1'b0, 32'h0);
        clear = 1'b0;

        run(1, mk_ir(5'b00111, 4'd4, 4'd3, 4'd7), -1, "ror");
        run(1, mk_ir(5'b01111, 4'd1, 4'd5, 4'd6), -1, "mul");
        run(1, mk_ir(5'b10010, 4'd2, 4'd9, 4'd0), -1, "not");
        run(1, mk_ir(5'b11111, 4'd3, 4'd3, 4'd3), -1, "bad1f");
        run(1, mk_ir(5'b10000, 4'd0, 4'd15, 4'd0), -1, "div");
        run(1, mk_ir(5'b10001, 4'd15, 4'd0, 4'd1), -1, "neg");
        run(1, mk_ir(5'b01000, 4'd8, 4'd10, 4'd11), -1, "op08");
        run(1, mk_ir(5'b10011, 4'd1, 4'd2, 4'd3), -1, "bad13");
        run(3, mk_ir(5'b00000, 4'd3, 4'd1, 4'd2), 2, "add_w3");
        run(3, mk_ir(5'b01111, 4'd6, 4'd7, 4'd8), 5, "mul_w3");

        // abort in T4 with clear
        irv = mk_ir(5'b00010, 4'd5, 4'd6, 4'd12);
        @(negedge clock);
        drive(1, 1'b1, irv);
        push_exp(irv, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive(1, 1'b0, irv);
            e = exp_q.pop_front();
            check($sformatf("abort[%0d]", i), snap1(), e);
        end
        exp_q.delete();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("abort_clr1", snap1(), ZERO);
        check("abort_clr3", snap3(), ZERO);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("abort_idle[%0d]", i), snap1(), ZERO);
        end
        run(1, mk_ir(5'b00101, 4'd9, 4'd13, 4'd14), -1, "after_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
